// File: rtl/rv_pkg.sv
// Definitions shared by the integer register file and its writeback buffer.
package rv_pkg;

    typedef logic [4:0] reg_index_t;

    function automatic int xlen(input bit rv64);
        return rv64 ? 64 : 32;
    endfunction

endpackage

// File: rtl/rv_x_regs_writeback_if.sv
// Result handshake from the execution units into the writeback buffer.
interface rv_x_regs_writeback_if
    import rv_pkg::*;
#(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    reg_index_t      in_rd;
    logic [XLEN-1:0] in_value;

    modport master (output in_valid, output in_rd, output in_value, input in_ready);
    modport slave  (input in_valid, input in_rd, input in_value, output in_ready);
endinterface

// File: rtl/rv_wb_fifo.sv
// Circular FIFO for pending writebacks; all storage is exposed for the forward search.
module rv_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [DEPTH-1:0][WIDTH-1:0]  mem_o,
    output logic [PW-1:0]                head_o,
    output logic [CW-1:0]                count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + PW'(1);
        if (do_pop)  head_d = head_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign mem_o   = mem_q;
    assign head_o  = head_q;
    assign count_o = count_q;
endmodule

// File: rtl/rv_x_regs_writeback.sv
// Writeback buffer in front of the register-file write port, with pending/forward lookup.
module rv_x_regs_writeback
    import rv_pkg::*;
#(
    parameter bit rv64  = 1'b1,
    parameter int depth = 4,
    localparam int XLEN = xlen(rv64),
    localparam int CW   = $clog2(depth) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    rv_x_regs_writeback_if.slave  in_if,
    input  logic                  hold,
    output reg_index_t            rd,
    output logic [XLEN-1:0]       rd_store_value,
    input  reg_index_t            rs1,
    input  reg_index_t            rs2,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic [XLEN-1:0]       rs1_forward_value,
    output logic [XLEN-1:0]       rs2_forward_value,
    output logic [CW-1:0]         count
);
    localparam int PW = $clog2(depth);

    typedef struct packed {
        reg_index_t      rd;
        logic [XLEN-1:0] value;
    } entry_t;

    typedef struct packed {
        logic            pending;
        logic [XLEN-1:0] value;
    } fwd_t;

    localparam int WIDTH = $bits(entry_t);

    logic [depth-1:0][WIDTH-1:0] entries;
    logic [WIDTH-1:0]            head_raw;
    entry_t                      head;
    logic [PW-1:0]               head_ptr;
    logic                        full, empty, push, pop;
    reg_index_t                  rd_q, rd_d;
    logic [XLEN-1:0]             rd_value_q, rd_value_d;
    fwd_t                        fwd1, fwd2;

    assign in_if.in_ready = !full;
    assign push = in_if.in_valid && !full && (in_if.in_rd != '0);
    assign pop  = !hold && !empty;

    rv_wb_fifo #(
        .DEPTH (depth),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_if.in_rd, in_if.in_value}),
        .rdata_o (head_raw),
        .mem_o   (entries),
        .head_o  (head_ptr),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign head = entry_t'(head_raw);

    // rd_value holds across hold/empty cycles; only rd == 0 signals "no write".
    always_comb begin
        rd_d       = '0;
        rd_value_d = rd_value_q;
        if (pop) begin
            rd_d       = head.rd;
            rd_value_d = head.value;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q       <= '0;
            rd_value_q <= '0;
        end else begin
            rd_q       <= rd_d;
            rd_value_q <= rd_value_d;
        end
    end

    // Output stage first, then FIFO oldest-to-youngest so the youngest match wins.
    function automatic fwd_t lookup(input reg_index_t rs);
        fwd_t   r;
        entry_t e;
        r = '0;
        if (rs != '0) begin
            if (rd_q == rs) begin
                r.pending = 1'b1;
                r.value   = rd_value_q;
            end
            for (int k = 0; k < depth; k++) begin
                e = entry_t'(entries[head_ptr + PW'(k)]);
                if ((CW'(k) < count) && (e.rd == rs)) begin
                    r.pending = 1'b1;
                    r.value   = e.value;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        fwd1 = lookup(rs1);
        fwd2 = lookup(rs2);
    end

    assign rd                = rd_q;
    assign rd_store_value    = rd_value_q;
    assign rs1_pending       = fwd1.pending;
    assign rs1_forward_value = fwd1.value;
    assign rs2_pending       = fwd2.pending;
    assign rs2_forward_value = fwd2.value;
endmodule

// File: tb/tb_rv_x_regs_writeback.sv
// Bench for rv_x_regs_writeback: queue-based reference model plus directed literal checks.
module tb_rv_x_regs_writeback;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold  = 1'b0;
    logic [4:0]  rs1 = '0, rs2 = '0;
    logic [4:0]  rd;
    logic [63:0] rd_store_value;
    logic        rs1_pending, rs2_pending;
    logic [63:0] rs1_forward_value, rs2_forward_value;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    rv_x_regs_writeback_if #(.XLEN(64)) bus ();

    rv_x_regs_writeback #(.rv64(1'b1), .depth(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .in_if             (bus),
        .hold              (hold),
        .rd                (rd),
        .rd_store_value    (rd_store_value),
        .rs1               (rs1),
        .rs2               (rs2),
        .rs1_pending       (rs1_pending),
        .rs2_pending       (rs2_pending),
        .rs1_forward_value (rs1_forward_value),
        .rs2_forward_value (rs2_forward_value),
        .count             (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queued results plus the value presented to the register file.
    logic [68:0] mq[$];
    logic [4:0]  m_rd  = '0;
    logic [63:0] m_val = '0;
    logic        m_acc;
    logic [68:0] m_e;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_rd  = '0;
            m_val = '0;
        end else begin
            m_acc = bus.in_valid && (mq.size() != DEPTH);
            if (!hold && mq.size() != 0) begin
                m_e   = mq.pop_front();
                m_rd  = m_e[68:64];
                m_val = m_e[63:0];
            end else begin
                m_rd = '0;
            end
            if (m_acc && bus.in_rd != 5'd0) mq.push_back({bus.in_rd, bus.in_value});
        end
    end

    function automatic logic [64:0] mfwd(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        for (int k = mq.size() - 1; k >= 0; k--)
            if (mq[k][68:64] == rs) return {1'b1, mq[k][63:0]};
        if (m_rd == rs) return {1'b1, m_val};
        return '0;
    endfunction

    always @(negedge clock) begin
        logic [64:0] f1, f2;
        f1 = mfwd(rs1);
        f2 = mfwd(rs2);
        chk("model_rd", 64'(rd), 64'(m_rd));
        if (m_rd != 5'd0 || !reset) chk("model_wdata", rd_store_value, m_val);
        chk("model_count", 64'(count), 64'(mq.size()));
        chk("model_in_ready", 64'(bus.in_ready), 64'(mq.size() != DEPTH));
        chk("model_rs1_pending", 64'(rs1_pending), 64'(f1[64]));
        chk("model_rs1_fwd", rs1_forward_value, f1[63:0]);
        chk("model_rs2_pending", 64'(rs2_pending), 64'(f2[64]));
        chk("model_rs2_fwd", rs2_forward_value, f2[63:0]);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic v, input logic [4:0] r, input logic [63:0] d);
        bus.in_valid = v;
        bus.in_rd    = r;
        bus.in_value = d;
    endtask

    logic [4:0]  seen_rd[$];
    logic [63:0] seen_val[$];

    initial begin
        offer(1'b0, 5'd0, 64'd0);
        #1 reset = 1'b0;
        #2;
        chk("reset_rd", 64'(rd), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_wdata", rd_store_value, 64'd0);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();

        // Single write
        rs1 = 5'd5;
        offer(1'b1, 5'd5, 64'h1234);
        cyc();
        offer(1'b0, 5'd0, 64'd0);
        chk("single_count", 64'(count), 64'd1);
        chk("single_pend_q", 64'(rs1_pending), 64'd1);
        chk("single_fwd_q", rs1_forward_value, 64'h1234);
        cyc();
        chk("single_rd", 64'(rd), 64'd5);
        chk("single_wdata", rd_store_value, 64'h1234);
        chk("single_pend_stage", 64'(rs1_pending), 64'd1);
        chk("single_fwd_stage", rs1_forward_value, 64'h1234);
        cyc();
        chk("single_rd_done", 64'(rd), 64'd0);
        chk("single_pend_done", 64'(rs1_pending), 64'd0);
        chk("single_fwd_done", rs1_forward_value, 64'd0);

        // x0 discard
        offer(1'b1, 5'd0, 64'hFFFF);
        cyc();
        offer(1'b0, 5'd0, 64'd0);
        chk("x0_count", 64'(count), 64'd0);
        cyc();
        chk("x0_rd", 64'(rd), 64'd0);

        // Fill with hold
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            offer(1'b1, 5'(i), 64'h100 + 64'(i));
            cyc();
        end
        offer(1'b0, 5'd0, 64'd0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_rd_held", 64'(rd), 64'd0);
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("drain_rd", 64'(rd), 64'(i));
            chk("drain_wdata", rd_store_value, 64'h100 + 64'(i));
            chk("drain_count", 64'(count), 64'(4 - i));
        end
        cyc();
        chk("drain_rd_end", 64'(rd), 64'd0);

        // Forward priority
        rs2  = 5'd7;
        hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            offer(1'b1, 5'd7, 64'(i));
            cyc();
        end
        offer(1'b0, 5'd0, 64'd0);
        chk("prio_pend", 64'(rs2_pending), 64'd1);
        chk("prio_fwd", rs2_forward_value, 64'd3);
        hold = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("prio_rd", 64'(rd), 64'd7);
            chk("prio_wdata", rd_store_value, 64'(i));
            chk("prio_fwd_drain", rs2_forward_value, 64'd3);
        end
        cyc();
        chk("prio_pend_end", 64'(rs2_pending), 64'd0);
        chk("prio_fwd_end", rs2_forward_value, 64'd0);

        // Concurrent push/pop at count 2 across pointer wrap
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) hold = 1'b0;
            offer(1'b1, 5'(10 + i), 64'hA000 + 64'(i));
            cyc();
            if (i >= 1) chk("concurrent_count", 64'(count), 64'd2);
            if (rd != 5'd0) begin
                seen_rd.push_back(rd);
                seen_val.push_back(rd_store_value);
            end
        end
        offer(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rd != 5'd0) begin
                seen_rd.push_back(rd);
                seen_val.push_back(rd_store_value);
            end
        end
        chk("concurrent_nwrites", 64'(seen_rd.size()), 64'd10);
        for (int k = 0; k < seen_rd.size() && k < 10; k++) begin
            chk("concurrent_order_rd", 64'(seen_rd[k]), 64'(10 + k));
            chk("concurrent_order_val", seen_val[k], 64'hA000 + 64'(k));
        end

        // Reset mid-stream: one write staged, three queued
        rs1  = 5'd20;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 5'(20 + i), 64'hB000 + 64'(i));
            cyc();
        end
        offer(1'b0, 5'd0, 64'd0);
        hold = 1'b0;
        cyc();
        chk("prereset_rd", 64'(rd), 64'd20);
        chk("prereset_count", 64'(count), 64'd3);
        #2 reset = 1'b0;
        #1;
        chk("midreset_rd", 64'(rd), 64'd0);
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midreset_pend", 64'(rs1_pending), 64'd0);
        cyc();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("postreset_rd", 64'(rd), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_x_regs_writeback.md
# rv_x_regs_writeback

Writeback buffer that feeds the single write port (`rd`, `rd_store_value`) of the integer register file. It accepts results from execution units over a valid/ready handshake and queues them in a small FIFO. It drains at most one result per cycle through a registered output stage. It also reports and forwards still-pending values for the two read addresses, so consumers see results that have not yet been committed.

## Interface
Parameters:
- `rv64`, 1, selects XLEN: 64 when 1, 32 when 0.
- `depth`, 4, FIFO entries; power of two, ≥ 2.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately while low.
- `in_valid`  in  1  result offered.
- `in_ready`  out  1  buffer can accept; equals count != depth.
- `in_rd`  in  5  destination register index.
- `in_value`  in  XLEN  result value.
- `hold`  in  1  register-file write port unavailable this cycle.
- `rd`  out  5  write index to register file; 0 = no write.
- `rd_store_value`  out  XLEN  write data to register file.
- `rs1`, `rs2`  in  5 each  read indices (same as driven to the register file).
- `rs1_pending`, `rs2_pending`  out  1 each  a queued or staged write targets that index.
- `rs1_forward_value`, `rs2_forward_value`  out  XLEN each  youngest pending value for that index, 0 if none.
- `count`  out  $clog2(depth)+1  occupied FIFO entries.

## Operation
- Enqueue on a posedge with `in_valid && in_ready`. Entry = {`in_rd`, `in_value`} written at the tail; tail advances mod `depth`.
- `in_rd == 0`: the handshake completes, nothing is stored, and count is unchanged.
- Output stage registers `rd`/`rd_store_value`. On each posedge:
  - `hold` = 1: load `rd` = 0 and leave `rd_store_value` unchanged; no pop.
  - `hold` = 0, FIFO non-empty: load the head entry and pop; head advances mod `depth`.
  - `hold` = 0, FIFO empty: load `rd` = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. When count == depth, `in_ready` = 0 even if a pop occurs that edge. No combinational ready-through-pop.
- Pending/forward, evaluated combinationally per read port over the valid FIFO entries plus the output stage when `rd` != 0:
  - Priority runs from youngest FIFO entry, to oldest FIFO entry, to output stage.
  - Index 0 never matches.
  - Same-cycle `in_*` is not considered.
- Arithmetic: pointers are $clog2(depth) bits and wrap naturally. Count never exceeds `depth` or goes below 0.

## Timing
- Reset values: `rd` = 0, `rd_store_value` = 0, `count` = 0, `in_ready` = 1, both pending = 0, both forward values = 0. Pointers are 0 and the FIFO contents are don't-care.
- Reset asserted mid-operation discards all queued and staged entries. No write reaches the register file after reset asserts.
- Latency with an empty buffer and `hold` = 0: accepted at edge N, `rd` valid after edge N+1, register file updated at edge N+2.
- Pending/forward cover an entry from edge N (enqueue) through edge N+2 (output stage replaced).
- Throughput: 1 result/cycle sustained with `hold` = 0.
- `in_ready` depends only on state, with no combinational path from `in_valid`.

## Structure
- Shared package `rv_pkg`: `xlen(rv64)` constant function and `reg_index_t` (5-bit typedef). The register file uses the same definitions.
- One sub-module: `rv_wb_fifo` (parameterised depth/width storage, pointers, count, full/empty). Forward search and output stage live in the top module.

## Test plan
- Reset: drive `reset` = 0 mid-stream with 3 entries queued → `rd` = 0, `count` = 0, `in_ready` = 1 immediately, no further writes after release.
- Single write: push {x5, 0x1234}, `hold` = 0 → `rd` = 5, `rd_store_value` = 0x1234 one edge later; `rs1` = 5 gives pending = 1, forward 0x1234 for 2 cycles.
- x0 discard: push {x0, 0xFFFF} → `count` stays 0 and `rd` stays 0.
- Fill with hold: `hold` = 1, push 5 results → 4 accepted, `in_ready` = 0 at count 4. Release `hold` → drains in order at one per cycle.
- Forward priority: queue {x7, 1}, {x7, 2}, {x7, 3} → `rs2` = 7 forwards 3, then 3 again as entries drain, then 0 with pending = 0 after the last leaves the output stage.
- Concurrent push/pop at count 2: count stays 2 and order is preserved across pointer wrap (push 10 entries total, then check the write sequence).
